// File: rtl/layer_sequencer.sv
// layer_sequencer: drives one dense layer through a single time-multiplexed
// MAC neuron. Issues neuron_go for each neuron index in turn, waits for
// neuron_done, requantizes the accumulator and stores it in the matching
// slot of the flattened layer_out vector.
// Optional build macro: LAYER_SEQ_RELU_EN fuses a ReLU into the requantizer.
module layer_sequencer #(
   parameter int NUM_NEURONS = 32,
   parameter int WIDTH_ACC   = 32,
   parameter int WIDTH_OUT   = 8,
   parameter int SHIFT       = 7
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               layer_go,
   output logic                               layer_busy,
   output logic                               layer_done,
   output logic                               neuron_go,
   input  logic                               neuron_done,
   input  logic [WIDTH_ACC-1:0]               neuron_result,
   output logic [$clog2(NUM_NEURONS)-1:0]     neuron_sel,
   output logic [NUM_NEURONS*WIDTH_OUT-1:0]   layer_out
);

   localparam int SEL_W = $clog2(NUM_NEURONS);
   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_NEURONS - 1);
   localparam logic signed [WIDTH_ACC-1:0] OUT_MAX = WIDTH_ACC'((1 << (WIDTH_OUT - 1)) - 1);
   localparam logic signed [WIDTH_ACC-1:0] OUT_MIN = ~OUT_MAX;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state, state_next;

   // Shift then clamp at full accumulator width so large values never alias.
   function automatic logic [WIDTH_OUT-1:0] requant(input logic signed [WIDTH_ACC-1:0] acc);
      logic signed [WIDTH_ACC-1:0] s;
      logic [WIDTH_OUT-1:0]        r;
      s = acc >>> SHIFT;
`ifdef LAYER_SEQ_RELU_EN
      if (s[WIDTH_ACC-1])
         r = '0;
      else if (s > OUT_MAX)
         r = OUT_MAX[WIDTH_OUT-1:0];
      else
         r = s[WIDTH_OUT-1:0];
`else
      if (s > OUT_MAX)
         r = OUT_MAX[WIDTH_OUT-1:0];
      else if (s < OUT_MIN)
         r = OUT_MIN[WIDTH_OUT-1:0];
      else
         r = s[WIDTH_OUT-1:0];
`endif
      return r;
   endfunction

   logic signed [WIDTH_ACC-1:0] acc_p0;
   logic [WIDTH_OUT-1:0]        slot_p0;
   logic                        last_p0;

   assign acc_p0  = neuron_result;
   assign slot_p0 = requant(acc_p0);
   assign last_p0 = (neuron_sel == LAST_SEL);

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic for the go/done handshake.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (layer_go) state_next = ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT:    if (neuron_done) state_next = last_p0 ? DONE : ISSUE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Registered Moore outputs, decoded from the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         neuron_go  <= 1'b0;
         layer_busy <= 1'b0;
         layer_done <= 1'b0;
      end else begin
         neuron_go  <= (state_next == ISSUE);
         layer_busy <= (state_next != IDLE);
         layer_done <= (state_next == DONE);
      end
   end

   // Neuron index and result slots; index only advances on WAIT->ISSUE.
   always_ff @(posedge clk) begin
      if (reset) begin
         neuron_sel <= '0;
         layer_out  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (layer_go) begin
                  neuron_sel <= '0;
                  layer_out  <= '0;
               end
            end
            WAIT: begin
               if (neuron_done) begin
                  for (int k = 0; k < NUM_NEURONS; k++) begin
                     if (neuron_sel == SEL_W'(k))
                        layer_out[k*WIDTH_OUT +: WIDTH_OUT] <= slot_p0;
                  end
                  if (!last_p0)
                     neuron_sel <= neuron_sel + SEL_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed self-checking bench for layer_sequencer with a 4-neuron layer and
// a neuron model that raises neuron_done three cycles after each neuron_go.
module tb_layer_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        layer_go;
   logic        layer_busy;
   logic        layer_done;
   logic        neuron_go;
   logic        neuron_done;
   logic [31:0] neuron_result;
   logic [1:0]  neuron_sel;
   logic [31:0] layer_out;

   logic        model_en;
   logic        man_done;
   logic [31:0] man_result;
   logic [31:0] res_tab [4];
   int          cnt;

   int tests = 0;
   int fails = 0;

   // run_layer recordings
   int          go_cnt;
   int          go_cyc [8];
   logic [1:0]  go_sel [8];
   logic [31:0] out_at_go [8];
   int          done_cnt;
   int          done_cyc;
   logic [31:0] final_out;
   logic        busy_after_done;
   logic        done_after_done;
   logic        timed_out;

   always #5 clk = ~clk;

   layer_sequencer #(
      .NUM_NEURONS(4), .WIDTH_ACC(32), .WIDTH_OUT(8), .SHIFT(7)
   ) dut (
      .clk(clk), .reset(reset), .layer_go(layer_go), .layer_busy(layer_busy),
      .layer_done(layer_done), .neuron_go(neuron_go), .neuron_done(neuron_done),
      .neuron_result(neuron_result), .neuron_sel(neuron_sel), .layer_out(layer_out)
   );

   // Neuron model: done pulse three cycles after go is seen.
   always @(posedge clk) begin
      if (neuron_go) cnt <= 3;
      else if (cnt != 0) cnt <= cnt - 1;
   end

   assign neuron_done   = man_done | (model_en && cnt == 1);
   assign neuron_result = model_en ? res_tab[neuron_sel] : man_result;

   // Runs a layer from IDLE; records events, no checking. With hold_go, stops
   // at the first neuron_go after layer_done.
   task automatic run_layer(input bit hold_go);
      go_cnt = 0; done_cnt = 0; done_cyc = -1; timed_out = 1'b1;
      final_out = '0; busy_after_done = 1'bx; done_after_done = 1'bx;
      @(negedge clk); layer_go = 1'b1;
      for (int cyc = 1; cyc < 200; cyc++) begin
         @(negedge clk);
         if (!hold_go) layer_go = 1'b0;
         if (neuron_go && go_cnt < 8) begin
            go_cyc[go_cnt] = cyc; go_sel[go_cnt] = neuron_sel;
            out_at_go[go_cnt] = layer_out; go_cnt++;
         end
         if (layer_done) begin
            done_cnt++;
            if (done_cnt == 1) begin done_cyc = cyc; final_out = layer_out; end
         end
         if (done_cyc > 0 && cyc == done_cyc + 1) begin
            busy_after_done = layer_busy; done_after_done = layer_done;
            if (!hold_go) begin timed_out = 1'b0; break; end
         end
         if (hold_go && done_cyc > 0 && neuron_go) begin timed_out = 1'b0; break; end
      end
      layer_go = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; layer_go = 1'b0; man_done = 1'b0; man_result = '0; model_en = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      tests++; if (neuron_go !== 1'b0) begin fails++; $display("FAIL reset_go got %b want 0", neuron_go); end
      tests++; if (neuron_sel !== 2'd0) begin fails++; $display("FAIL reset_sel got %0d want 0", neuron_sel); end
      tests++; if (layer_out !== 32'h0) begin fails++; $display("FAIL reset_out got %h want 0", layer_out); end
      tests++; if (layer_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", layer_done); end
      tests++; if (layer_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", layer_busy); end
   endtask

   task automatic test_basic_layer;
      res_tab[0] = 32'd640; res_tab[1] = 32'd256; res_tab[2] = 32'd0; res_tab[3] = 32'd127;
      run_layer(1'b0);
      tests++; if (timed_out) begin fails++; $display("FAIL basic_timeout got timeout want layer_done"); end
      tests++; if (go_cnt !== 4) begin fails++; $display("FAIL basic_go_count got %0d want 4", go_cnt); end
      for (int i = 0; i < 4 && i < go_cnt; i++) begin
         tests++;
         if (go_sel[i] !== 2'(i) || go_cyc[i] !== 1 + 4*i) begin
            fails++; $display("FAIL basic_go%0d got sel %0d cyc %0d want sel %0d cyc %0d",
                              i, go_sel[i], go_cyc[i], i, 1 + 4*i);
         end
      end
      if (go_cnt > 1) begin
         tests++; if (out_at_go[1] !== 32'h0000_0005) begin fails++; $display("FAIL basic_partial got %h want 00000005", out_at_go[1]); end
      end
      tests++; if (done_cyc !== 17) begin fails++; $display("FAIL basic_done_cyc got %0d want 17", done_cyc); end
      tests++; if (final_out !== 32'h0000_0205) begin fails++; $display("FAIL basic_out got %h want 00000205", final_out); end
      tests++; if (done_after_done !== 1'b0 || busy_after_done !== 1'b0) begin
         fails++; $display("FAIL basic_done_pulse got done %b busy %b want 0 0", done_after_done, busy_after_done); end
      repeat (3) @(negedge clk);
      tests++; if (layer_out !== 32'h0000_0205) begin fails++; $display("FAIL basic_hold got %h want 00000205", layer_out); end
   endtask

   task automatic test_saturation;
      logic [31:0] exp;
      res_tab[0] = 32'd65536; res_tab[1] = -32'sd100000; res_tab[2] = 32'd16256; res_tab[3] = -32'sd16384;
`ifdef LAYER_SEQ_RELU_EN
      exp = 32'h007F_007F;
`else
      exp = 32'h807F_807F;
`endif
      run_layer(1'b0);
      tests++; if (go_cnt < 1 || out_at_go[0] !== 32'h0) begin fails++; $display("FAIL sat_cleared got %h want 0", out_at_go[0]); end
      tests++; if (timed_out || final_out !== exp) begin fails++; $display("FAIL sat_out got %h want %h", final_out, exp); end
   endtask

   task automatic test_negative;
      logic [31:0] exp;
      res_tab[0] = -32'sd300; res_tab[1] = -32'sd1; res_tab[2] = 32'd16383; res_tab[3] = -32'sd129;
`ifdef LAYER_SEQ_RELU_EN
      exp = 32'h007F_0000;
`else
      exp = 32'hFE7F_FFFD;
`endif
      run_layer(1'b0);
      tests++; if (timed_out || final_out !== exp) begin fails++; $display("FAIL neg_out got %h want %h", final_out, exp); end
   endtask

   task automatic test_ignored_inputs;
      int dones;
      model_en = 1'b0; dones = 0;
      @(negedge clk); layer_go = 1'b1;
      @(negedge clk); layer_go = 1'b0;
      tests++; if (neuron_go !== 1'b1) begin fails++; $display("FAIL ign_issue got go %b want 1", neuron_go); end
      man_done = 1'b1; man_result = 32'd640;
      @(negedge clk); man_done = 1'b0;
      tests++; if (neuron_sel !== 2'd0 || layer_out !== 32'h0) begin
         fails++; $display("FAIL ign_spurious_done got sel %0d out %h want 0 0", neuron_sel, layer_out); end
      layer_go = 1'b1;
      @(negedge clk); layer_go = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (layer_done || neuron_go) dones++;
      end
      tests++; if (dones !== 0 || layer_busy !== 1'b1 || neuron_sel !== 2'd0 || layer_out !== 32'h0) begin
         fails++; $display("FAIL ign_wait got events %0d busy %b sel %0d out %h want 0 1 0 0",
                           dones, layer_busy, neuron_sel, layer_out); end
      man_done = 1'b1; man_result = 32'd640;
      @(negedge clk); man_done = 1'b0;
      tests++; if (neuron_sel !== 2'd1 || neuron_go !== 1'b1 || layer_out !== 32'h5) begin
         fails++; $display("FAIL ign_accept got sel %0d go %b out %h want 1 1 00000005", neuron_sel, neuron_go, layer_out); end
      @(negedge clk); man_done = 1'b1; man_result = 32'd256;
      @(negedge clk); man_done = 1'b0;
      @(negedge clk);
      tests++; if (neuron_sel !== 2'd2 || neuron_go !== 1'b0 || layer_busy !== 1'b1) begin
         fails++; $display("FAIL ign_sel2 got sel %0d go %b busy %b want 2 0 1", neuron_sel, neuron_go, layer_busy); end
   endtask

   task automatic test_reset_mid_layer;
      // Continues from WAIT with neuron_sel = 2.
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      tests++; if ({neuron_go, layer_busy, layer_done} !== 3'b000 || neuron_sel !== 2'd0 || layer_out !== 32'h0) begin
         fails++; $display("FAIL midreset got go/busy/done %b sel %0d out %h want 000 0 0",
                           {neuron_go, layer_busy, layer_done}, neuron_sel, layer_out); end
      @(negedge clk);
      tests++; if (layer_busy !== 1'b0) begin fails++; $display("FAIL midreset_idle got busy %b want 0", layer_busy); end
      model_en = 1'b1;
      res_tab[0] = 32'd640; res_tab[1] = 32'd256; res_tab[2] = 32'd0; res_tab[3] = 32'd127;
      run_layer(1'b0);
      tests++; if (go_cnt < 1 || go_sel[0] !== 2'd0 || go_cyc[0] !== 1) begin
         fails++; $display("FAIL midreset_restart got sel %0d cyc %0d want 0 1", go_sel[0], go_cyc[0]); end
      tests++; if (timed_out || final_out !== 32'h0000_0205) begin fails++; $display("FAIL midreset_out got %h want 00000205", final_out); end
   endtask

   task automatic test_back_to_back;
      int last_go;
      res_tab[0] = 32'd128; res_tab[1] = 32'd256; res_tab[2] = 32'd384; res_tab[3] = 32'd512;
      run_layer(1'b1);
      last_go = (go_cnt > 0) ? go_cyc[go_cnt-1] : -1;
      tests++; if (timed_out || go_cnt !== 5) begin fails++; $display("FAIL b2b_restart got gos %0d timeout %b want 5 0", go_cnt, timed_out); end
      tests++; if (last_go !== done_cyc + 2 || busy_after_done !== 1'b0) begin
         fails++; $display("FAIL b2b_gap got go cyc %0d busy %b want %0d 0", last_go, busy_after_done, done_cyc + 2); end
      tests++; if (final_out !== 32'h0403_0201) begin fails++; $display("FAIL b2b_first_out got %h want 04030201", final_out); end
      if (go_cnt > 0) begin
         tests++; if (go_sel[go_cnt-1] !== 2'd0 || out_at_go[go_cnt-1] !== 32'h0) begin
            fails++; $display("FAIL b2b_second_start got sel %0d out %h want 0 0", go_sel[go_cnt-1], out_at_go[go_cnt-1]); end
      end
      timed_out = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (layer_done) begin timed_out = 1'b0; break; end
      end
      tests++; if (timed_out || layer_out !== 32'h0403_0201) begin
         fails++; $display("FAIL b2b_second_out got %h timeout %b want 04030201 0", layer_out, timed_out); end
   endtask

   initial begin
      cnt = 0;
      test_reset();
      test_basic_layer();
      test_saturation();
      test_negative();
      test_ignored_inputs();
      test_reset_mid_layer();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
